// File: rtl/pcm_serializer.sv
// I2S-style mono PCM transmitter: one-deep holding register feeding a frame shift word,
// sent MSB first one BCLK after each WS edge, identical data in left and right slots.
module pcm_serializer #(
    parameter int WIDTH = 18,
    parameter int SLOT  = 32
) (
    input  logic                    BCLK,
    input  logic                    RESET,
    input  logic                    EN,
    input  logic signed [WIDTH-1:0] DIN,
    input  logic                    DIN_VALID,
    output logic                    DIN_READY,
    output logic                    WS,
    output logic                    SD_OUT,
    output logic                    FRAME_ST,
    output logic                    UNDERRUN
);

    localparam int FRAME = 2 * SLOT;
    localparam int CW    = $clog2(FRAME);
    localparam logic [CW-1:0] LAST    = CW'(FRAME - 1);
    localparam logic [CW-1:0] SLOT_CW = CW'(SLOT);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt, j_nxt;
    logic                    stop_req, stop_nxt;
    logic                    hold_full, hold_full_nxt;
    logic signed [WIDTH-1:0] hold, hold_nxt;
    logic signed [WIDTH-1:0] shift, shift_nxt;
    logic                    accept, frame_start;
    logic                    ws_nxt, sd_nxt, und_nxt;

    always_ff @(posedge BCLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            stop_req  <= 1'b0;
            hold_full <= 1'b0;
            hold      <= '0;
            shift     <= '0;
            DIN_READY <= 1'b1;
            WS        <= 1'b0;
            SD_OUT    <= 1'b0;
            FRAME_ST  <= 1'b0;
            UNDERRUN  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            stop_req  <= stop_nxt;
            hold_full <= hold_full_nxt;
            hold      <= hold_nxt;
            shift     <= shift_nxt;
            DIN_READY <= ~hold_full_nxt;
            WS        <= ws_nxt;
            SD_OUT    <= sd_nxt;
            FRAME_ST  <= frame_start;
            UNDERRUN  <= und_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        stop_nxt      = stop_req;
        frame_start   = 1'b0;
        accept        = DIN_VALID & ~hold_full;
        shift_nxt     = shift;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        und_nxt       = 1'b0;
        j_nxt         = '0;
        ws_nxt        = 1'b0;
        sd_nxt        = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                stop_nxt = 1'b0;
                if (EN) begin
                    state_nxt   = RUN;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                // A stop request seen anywhere in the frame is honoured only at the wrap.
                if (!EN)
                    stop_nxt = 1'b1;
                if (cnt == LAST) begin
                    cnt_nxt = '0;
                    if (stop_req || !EN) begin
                        state_nxt = IDLE;
                        stop_nxt  = 1'b0;
                    end else begin
                        frame_start = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Frame-start decision uses the pre-edge hold_full, so a colliding accept lands in hold.
        if (frame_start) begin
            if (hold_full) begin
                shift_nxt     = hold;
                hold_full_nxt = 1'b0;
            end else begin
                und_nxt = 1'b1;
            end
        end
        if (accept) begin
            hold_nxt      = DIN;
            hold_full_nxt = 1'b1;
        end

        ws_nxt = (cnt_nxt >= SLOT_CW);
        j_nxt  = ws_nxt ? (cnt_nxt - SLOT_CW) : cnt_nxt;
        // Slot position j (1..WIDTH) carries bit WIDTH-j; j=0 is the I2S one-bit delay.
        for (int b = 0; b < WIDTH; b++) begin
            if (j_nxt == CW'(WIDTH - b))
                sd_nxt = shift[b];
        end
    end

endmodule
